// File: rtl/ov7670_pkg.sv
// ov7670_pkg: timing constants, pattern/channel types and colour-bar table for the OV7670 stream emulator.
package ov7670_pkg;
    localparam int H_ACTIVE    = 640;
    localparam int H_TOTAL     = 784;
    localparam int V_ACTIVE    = 480;
    localparam int V_TOTAL     = 510;
    localparam int VSYNC_LINES = 3;
    localparam int V_START     = 20;
    localparam int HW          = 10;
    localparam int VW          = 9;

    typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_COUNT} pattern_e;
    typedef enum logic [1:0] {CH_B, CH_G, CH_R} bayer_ch_e;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    // Entries are {R,G,B}; index 0 is the leftmost bar: W,Y,C,G,M,R,B,K.
    localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};

    // BGGR mosaic: even rows B,G; odd rows G,R.
    function automatic bayer_ch_e bayer_ch(input logic x0, input logic y0);
        if (!y0 && !x0) return CH_B;
        if (y0 && x0) return CH_R;
        return CH_G;
    endfunction
endpackage

// File: rtl/ov7670_stream_emulator_bayer_pattern_gen.sv
// bayer_pattern_gen: combinational raw-Bayer byte for one pixel of the selected test pattern.
module bayer_pattern_gen
    import ov7670_pkg::*;
(
    input  logic [HW-1:0] x_i,
    input  logic [4:0]    y_i,
    input  pattern_e      pat_i,
    input  logic [7:0]    frame_cnt_i,
    output logic [7:0]    d_o
);
    logic [2:0] rgb;
    bayer_ch_e  ch;
    logic       bar_bit;

    always_comb begin
        rgb     = BAR_RGB[3'(x_i / HW'(80))];
        ch      = bayer_ch(x_i[0], y_i[0]);
        bar_bit = ch == CH_R ? rgb[2] : ch == CH_G ? rgb[1] : rgb[0];
        d_o     = pat_i == PAT_BARS  ? {8{bar_bit}} :
                  pat_i == PAT_RAMP  ? x_i[9:2] :
                  pat_i == PAT_CHECK ? {8{x_i[4] ^ y_i[4]}} : frame_cnt_i;
    end
endmodule

// File: rtl/ov7670_stream_emulator.sv
// ov7670_stream_emulator: OV7670-style PCLK/VSYNC/HREF/D transmitter producing raw-Bayer test frames.
module ov7670_stream_emulator
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE_P    = H_ACTIVE,
    parameter int H_TOTAL_P     = H_TOTAL,
    parameter int V_ACTIVE_P    = V_ACTIVE,
    parameter int V_TOTAL_P     = V_TOTAL,
    parameter int VSYNC_LINES_P = VSYNC_LINES,
    parameter int V_START_P     = V_START
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [1:0]  i_pattern,
    output logic        o_pclk,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_d,
    output logic        o_frame_done,
    output logic [15:0] o_frame_count
);
    state_e          state_q, state_d;
    pattern_e        pat_q, pat_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            pclk_q, vsync_q, href_q, done_q;
    logic [7:0]      d_q;
    logic            fall, h_last, eof, active, done_d, vsync_d, href_d;
    logic [4:0]      y_lo;
    logic [7:0]      pix, d_d;

    // Everything below computes the pixel about to be shown, so the output
    // registers capture it on the same edge the counters move to it.
    always_comb begin
        fall    = pclk_q;
        h_last  = h_q == HW'(H_TOTAL_P - 1);
        eof     = h_last && v_q == VW'(V_TOTAL_P - 1);
        state_d = state_q;
        pat_d   = pat_q;
        h_d     = h_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        active  = 1'b0;
        if (fall) begin
            if (state_q == ST_IDLE) begin
                if (i_enable) begin
                    state_d = ST_RUN;
                    pat_d   = pattern_e'(i_pattern);
                    active  = 1'b1;
                end
            end else if (eof) begin
                done_d = 1'b1;
                cnt_d  = cnt_q + 16'd1;
                h_d    = '0;
                v_d    = '0;
                active = i_enable;
                if (i_enable) pat_d = pattern_e'(i_pattern);
                else state_d = ST_IDLE;
            end else begin
                active = 1'b1;
                h_d    = h_last ? '0 : h_q + 1'b1;
                v_d    = h_last ? v_q + 1'b1 : v_q;
            end
        end
        y_lo    = 5'(v_d - VW'(V_START_P));
        vsync_d = active && v_d < VW'(VSYNC_LINES_P);
        href_d  = active && v_d >= VW'(V_START_P) && v_d < VW'(V_START_P + V_ACTIVE_P)
                  && h_d < HW'(H_ACTIVE_P);
        d_d     = href_d ? pix : 8'h00;
    end

    bayer_pattern_gen u_gen (
        .x_i        (h_d),
        .y_i        (y_lo),
        .pat_i      (pat_d),
        .frame_cnt_i(cnt_q[7:0]),
        .d_o        (pix)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_BARS;
            h_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            pclk_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            h_q     <= h_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            pclk_q  <= ~pclk_q;
            done_q  <= done_d;
            if (fall) begin
                vsync_q <= vsync_d;
                href_q  <= href_d;
                d_q     <= d_d;
            end
        end
    end

    assign o_pclk        = pclk_q;
    assign o_vsync       = vsync_q;
    assign o_href        = href_q;
    assign o_d           = d_q;
    assign o_frame_done  = done_q;
    assign o_frame_count = cnt_q;
endmodule

// File: tb/tb_ov7670_stream_emulator.sv
// tb_ov7670_stream_emulator: directed checks on a full-width line with a short 6-line frame
// (1 VSYNC line, active lines 2..4) so several frames fit in a short run.
module tb_ov7670_stream_emulator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_enable = 1'b0;
    logic [1:0]  i_pattern = 2'd0;
    logic        o_pclk, o_vsync, o_href, o_frame_done;
    logic [7:0]  o_d;
    logic [15:0] o_frame_count;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rises = 0;
    logic        href_prev = 1'b0;

    ov7670_stream_emulator #(
        .H_ACTIVE_P(640), .H_TOTAL_P(784), .V_ACTIVE_P(3),
        .V_TOTAL_P(6), .VSYNC_LINES_P(1), .V_START_P(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_pattern    (i_pattern),
        .o_pclk       (o_pclk),
        .o_vsync      (o_vsync),
        .o_href       (o_href),
        .o_d          (o_d),
        .o_frame_done (o_frame_done),
        .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        rises     <= rises + int'(o_href && !href_prev);
        href_prev <= o_href;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the e-th rising edge since the last reset release.
    task automatic goto(input int e);
        repeat (e - cyc) @(posedge clk);
        cyc = e;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pclk"}, o_pclk, 0);
        chk({tag, "_vsync"}, o_vsync, 0);
        chk({tag, "_href"}, o_href, 0);
        chk({tag, "_d"}, o_d, 0);
        chk({tag, "_done"}, o_frame_done, 0);
        chk({tag, "_count"}, o_frame_count, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        i_enable = 1'b1;
        reset = 1'b0;
        cyc = 0;
        goto(1);
        chk("e1_pclk", o_pclk, 1);
        chk("e1_vsync", o_vsync, 0);
        goto(2);
        chk("e2_vsync", o_vsync, 1);
        chk("e2_pclk", o_pclk, 0);
        chk("e2_href", o_href, 0);
        goto(1569); chk("vsync_last", o_vsync, 1);
        goto(1570); chk("vsync_end", o_vsync, 0);
        goto(3137); chk("href_pre", o_href, 0);
        goto(3138); chk("href_first", o_href, 1); chk("bar_x0", o_d, 8'hFF);
        goto(3140); chk("bar_x1", o_d, 8'hFF);
        goto(3298); chk("bar_yel_b", o_d, 8'h00);
        goto(3938); chk("bar_red_b", o_d, 8'h00);
        goto(3940); chk("bar_red_g", o_d, 8'h00);
        goto(4416); chk("href_x639", o_href, 1);
        goto(4418); chk("href_x640", o_href, 0); chk("d_blank", o_d, 8'h00);
        goto(4706); chk("href_y1", o_href, 1); chk("bar_y1_x0", o_d, 8'hFF);
        goto(5508); chk("bar_red_r", o_d, 8'hFF);
        i_pattern = 2'd1;
        goto(6282); chk("pat_hold", o_d, 8'hFF);
        goto(9409); chk("done_pre", o_frame_done, 0); chk("count_pre", o_frame_count, 0);
        chk("href_pulses1", rises, 3);
        goto(9410); chk("done1", o_frame_done, 1); chk("count1", o_frame_count, 1);
        chk("vsync_f2", o_vsync, 1);
        goto(9411); chk("done1_end", o_frame_done, 0);
        goto(12554); chk("ramp_x4", o_d, 8'h01);
        goto(13818); chk("ramp_x636", o_d, 8'h9F);
        goto(14000);
        i_pattern = 2'd2;
        i_enable = 1'b0;
        goto(14130); chk("ramp_hold", o_d, 8'h02);
        goto(18817); chk("done2_pre", o_frame_done, 0); chk("count2_pre", o_frame_count, 1);
        goto(18818); chk("done2", o_frame_done, 1); chk("count2", o_frame_count, 2);
        chk("idle_vsync", o_vsync, 0); chk("idle_href", o_href, 0);
        chk("href_pulses2", rises, 6);
        goto(18819); chk("idle_pclk_hi", o_pclk, 1); chk("done2_end", o_frame_done, 0);
        goto(18820); chk("idle_pclk_lo", o_pclk, 0);
        goto(20000); chk("idle_vsync2", o_vsync, 0); chk("idle_d", o_d, 0);
        chk("idle_count", o_frame_count, 2);
        i_enable = 1'b1;
        goto(20001); chk("restart_pre", o_vsync, 0);
        goto(20002); chk("restart_vsync", o_vsync, 1);
        goto(23170); chk("check_x16", o_d, 8'hFF);
        goto(23202); chk("check_x32", o_d, 8'h00);
        goto(23234); chk("check_x48", o_d, 8'hFF);
        goto(23300); chk("midline_href", o_href, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        i_pattern = 2'd3;
        #1;
        reset = 1'b0;
        cyc = 0;
        goto(1); chk("r_e1_vsync", o_vsync, 0);
        goto(2); chk("r_e2_vsync", o_vsync, 1); chk("r_e2_href", o_href, 0);
        goto(3138); chk("r_href", o_href, 1); chk("count_pat0", o_d, 8'h00);
        goto(9410); chk("r_done", o_frame_done, 1); chk("r_count", o_frame_count, 1);
        goto(12546); chk("count_pat1_x0", o_d, 8'h01);
        goto(12556); chk("count_pat1_x5", o_d, 8'h01);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
